// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, clock out 8 data bits,
// odd parity and stop on device falling edges, then check the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES       = 10000,
  parameter int REQ_CYCLES           = 16,
  parameter int START_TIMEOUT_CYCLES = 1500000,
  parameter int XFER_TIMEOUT_CYCLES  = 200000,
  parameter int FILTER_CYCLES        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int TMR_W = $clog2(START_TIMEOUT_CYCLES + 1);
  localparam int FLT_W = $clog2(FILTER_CYCLES + 1);

  localparam logic [TMR_W-1:0] INHIBIT_LAST = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] REQ_LAST     = TMR_W'(REQ_CYCLES - 1);
  localparam logic [TMR_W-1:0] START_LAST   = TMR_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] XFER_LAST    = TMR_W'(XFER_TIMEOUT_CYCLES - 1);
  localparam logic [FLT_W-1:0] FLT_LAST     = FLT_W'(FILTER_CYCLES - 1);

  localparam logic [1:0] ERR_NO_CLK = 2'b01;
  localparam logic [1:0] ERR_XFER   = 2'b10;
  localparam logic [1:0] ERR_NACK   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_WAIT_CLK, S_SEND, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  state_t state_q, state_d;

  logic             clk_sync_p0, clk_sync_p1;
  logic             data_sync_p0, data_sync_p1;
  logic             clk_flt, clk_flt_d;
  logic [FLT_W-1:0] flt_cnt;
  logic             clk_fall;

  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] xfer_tmr;
  logic [FLT_W-1:0] idle_cnt;
  logic [3:0]       bit_n;
  logic [9:0]       oe_sh;
  logic             bit_oe;
  logic [1:0]       err_d;
  logic             accept;
  logic             shift_en;
  logic             line_idle;

  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
    return (v == {TMR_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Stage p0/p1: two-flop synchronizers on the raw pins (idle level is high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_p0  <= 1'b1;
      clk_sync_p1  <= 1'b1;
      data_sync_p0 <= 1'b1;
      data_sync_p1 <= 1'b1;
    end else begin
      clk_sync_p0  <= ps2_clk_in;
      clk_sync_p1  <= clk_sync_p0;
      data_sync_p0 <= ps2_data_in;
      data_sync_p1 <= data_sync_p0;
    end
  end

  // Stage p2: a new clock level is taken only after FILTER_CYCLES of agreement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_flt   <= 1'b1;
      clk_flt_d <= 1'b1;
      flt_cnt   <= '0;
    end else begin
      clk_flt_d <= clk_flt;
      if (clk_sync_p1 == clk_flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        clk_flt <= clk_sync_p1;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign clk_fall  = clk_flt_d & ~clk_flt;
  assign line_idle = clk_sync_p1 & data_sync_p1;

  always_comb begin
    state_d  = state_q;
    err_d    = err_code;
    accept   = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          accept  = 1'b1;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: if (tmr == INHIBIT_LAST) state_d = S_REQ;
      S_REQ:     if (tmr == REQ_LAST)     state_d = S_WAIT_CLK;
      S_WAIT_CLK: begin
        if (tmr == START_LAST) begin
          state_d = S_ERR;
          err_d   = ERR_NO_CLK;
        end else if (clk_fall) begin
          state_d  = S_SEND;
          shift_en = 1'b1;
        end
      end
      S_SEND: begin
        // A timeout landing on the same cycle as an edge takes precedence
        if (xfer_tmr == XFER_LAST) begin
          state_d = S_ERR;
          err_d   = ERR_XFER;
        end else if (clk_fall) begin
          if (bit_n == 4'd10) begin
            if (data_sync_p1) begin
              state_d = S_ERR;
              err_d   = ERR_NACK;
            end else begin
              state_d = S_WAIT_IDLE;
            end
          end else begin
            shift_en = 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (xfer_tmr == XFER_LAST) begin
          state_d = S_ERR;
          err_d   = ERR_XFER;
        end else if (line_idle && idle_cnt == FLT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tmr      <= '0;
      xfer_tmr <= '0;
      idle_cnt <= '0;
      bit_n    <= '0;
      err_code <= 2'b00;
    end else begin
      state_q  <= state_d;
      tmr      <= (state_d != state_q) ? '0 : sat_inc(tmr);
      // Transfer timer spans SEND and WAIT_IDLE, starting at the first device edge
      xfer_tmr <= (state_d == S_SEND && state_q != S_SEND) ? '0 : sat_inc(xfer_tmr);
      idle_cnt <= (state_q == S_WAIT_IDLE && line_idle) ? idle_cnt + 1'b1 : '0;
      if (shift_en) bit_n <= (state_q == S_WAIT_CLK) ? 4'd1 : bit_n + 4'd1;
      if (accept) begin
        err_code <= 2'b00;
      end else if (state_d == S_ERR && state_q != S_ERR) begin
        err_code <= err_d;
      end
    end
  end

  // Frame shifter holds pull-low enables: ~data LSB first, ~odd parity, released stop
  always_ff @(posedge clk) begin
    if (accept) begin
      oe_sh <= {1'b0, ^tx_data, ~tx_data};
    end else if (shift_en) begin
      bit_oe <= oe_sh[0];
      oe_sh  <= {1'b0, oe_sh[9:1]};
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign tx_done     = (state_q == S_DONE);
  assign tx_err      = (state_q == S_ERR);
  assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_REQ);
  assign ps2_data_oe = (state_q == S_REQ) || (state_q == S_WAIT_CLK) ||
                       ((state_q == S_SEND) && bit_oe);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx: a behavioural PS/2 device on wired-AND lines,
// expected outcomes queued at issue time and checked by an independent monitor.
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int REQ = 16;
  localparam int STO = 3000;
  localparam int XTO = 2500;
  localparam int FLT = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_err;
  logic [1:0] err_code;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  always #5 clk = ~clk;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .REQ_CYCLES(REQ), .START_TIMEOUT_CYCLES(STO),
    .XFER_TIMEOUT_CYCLES(XTO), .FILTER_CYCLES(FLT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .tx_done(tx_done), .tx_err(tx_err),
    .err_code(err_code), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  typedef struct packed {
    logic       is_err;
    logic [1:0] code;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         fails = 0;
  int         cyc = 0;
  int         n_accept = 0;
  int         t_clk_rise = 0, t_data_rise = 0, t_wc = 0, t_edge1 = 0;
  int         last_lat = -1;
  int         rx_n = 0;
  logic [9:0] rx_bits = '0;
  logic       prev_clk_oe = 1'b0, prev_data_oe = 1'b0;
  logic [1:0] model_code = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rst_n && tx_valid && tx_ready) n_accept++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame as the device should see it: 8 data bits LSB first, odd parity, stop = 1
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (ps2_clk_oe && !prev_clk_oe) t_clk_rise = cyc;
      if (ps2_data_oe && !prev_data_oe && ps2_clk_oe) begin
        chk("start_bit_delay", cyc - t_clk_rise, INH);
        t_data_rise = cyc;
      end
      if (!ps2_clk_oe && prev_clk_oe) begin
        chk("req_hold", cyc - t_data_rise, REQ);
        chk("start_bit_kept", ps2_data_oe, 1);
        t_wc = cyc;
      end
      if (tx_done || tx_err) begin
        chk("pulse_exclusive", tx_done & tx_err, 0);
        chk("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("pulse_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("pulse_kind_err", tx_err, mon_e.is_err);
          chk("err_code", err_code, mon_e.code);
          if (!mon_e.is_err || mon_e.code == 2'b11) begin
            chk("rx_bit_count", rx_n, 10);
            chk("rx_frame", rx_bits, frame_of(mon_e.data));
          end
          if (mon_e.is_err && mon_e.code == 2'b01) chk("start_timeout_at", cyc - t_wc, STO);
          if (mon_e.is_err && mon_e.code == 2'b10)
            chk("xfer_timeout_at", cyc - t_edge1, FLT + 3 + XTO);
        end
      end
    end
    prev_clk_oe  = ps2_clk_oe;
    prev_data_oe = ps2_data_oe;
  end

  task automatic send(input logic [7:0] b, input bit expect_pulse, input bit is_err,
                      input logic [1:0] code);
    bit ok = 0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1; break; end
    end
    chk("ready_before_send", ok, 1);
    chk("err_code_held", err_code, model_code);
    if (expect_pulse) sb.push_back('{is_err: is_err, code: code, data: b});
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("accept_state", {busy, ps2_clk_oe, ps2_data_oe, tx_ready}, 4'b1100);
    chk("err_code_cleared", err_code, 0);
    model_code = (expect_pulse && is_err) ? code : 2'b00;
  endtask

  // Device side: waits for request-to-send, clocks n_edges falling edges, samples on rise
  task automatic dev_xfer(input int n_edges, input int half, input bit ack_val,
                          input int glitch_after);
    bit ok = 0;
    for (int i = 0; i < INH + REQ + 100; i++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_data_oe) begin ok = 1; break; end
    end
    chk("rts_seen", ok, 1);
    rx_n    = 0;
    rx_bits = '0;
    if (!ok) return;
    repeat (half) @(negedge clk);
    for (int k = 1; k <= n_edges; k++) begin
      dev_clk = 1'b0;
      if (k == 1) begin t_edge1 = cyc; last_lat = -1; end
      for (int j = 1; j < half; j++) begin
        @(negedge clk);
        if (k == 1 && last_lat < 0 && !ps2_data_oe) last_lat = j;
      end
      @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) begin rx_bits[k-1] = ps2_data_in; rx_n++; end
      if (k == 10) dev_data = ack_val;
      if (k == glitch_after) begin
        repeat (10) @(negedge clk);
        dev_clk = 1'b0;
        repeat (5) @(negedge clk);
        dev_clk = 1'b1;
        repeat (half - 15) @(negedge clk);
      end else begin
        repeat (half) @(negedge clk);
      end
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_quiet(input int limit);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && tx_ready) begin ok = 1; break; end
    end
    chk("transfer_finished", ok, 1);
  endtask

  task automatic run_xfer(input logic [7:0] b, input int n_edges, input int half,
                          input bit ack_val, input int glitch_after, input bit is_err,
                          input logic [1:0] code);
    send(b, 1'b1, is_err, code);
    dev_xfer(n_edges, half, ack_val, glitch_after);
    if (n_edges >= 1 && b[0]) chk("edge_latency", last_lat, FLT + 3);
    wait_quiet(STO + XTO + 1000);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: cycle %0d reached, required completion before budget", cyc);
    $fatal(1);
  end

  initial begin
    int a0;
    bit ok;
    logic [7:0] b;
    int half;
    bit nack;

    repeat (3) @(negedge clk);
    chk("reset_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pulses", {tx_done, tx_err}, 0);
    chk("reset_err_code", err_code, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", tx_ready, 1);

    run_xfer(8'hED, 11, 50, 1'b0, 0, 1'b0, 2'b00);
    run_xfer(8'h00, 11, 40, 1'b0, 0, 1'b0, 2'b00);
    run_xfer(8'hFF, 11, 60, 1'b0, 0, 1'b0, 2'b00);
    run_xfer(8'h01, 11, 35, 1'b0, 0, 1'b0, 2'b00);
    run_xfer(8'hA5, 11, 50, 1'b0, 3, 1'b0, 2'b00);
    run_xfer(8'hF3, 11, 45, 1'b1, 0, 1'b1, 2'b11);
    run_xfer(8'h96, 5,  50, 1'b0, 0, 1'b1, 2'b10);
    run_xfer(8'h11, 0,  40, 1'b0, 0, 1'b1, 2'b01);

    // Reset in the middle of the data bits
    send(8'h5A, 1'b0, 1'b0, 2'b00);
    dev_xfer(4, 40, 1'b0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_pulses", {tx_done, tx_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_code = 2'b00;
    @(negedge clk);
    chk("ready_after_midreset", tx_ready, 1);
    repeat (60) @(negedge clk);

    // tx_valid held across a whole transfer
    @(negedge clk);
    chk("err_code_held", err_code, model_code);
    sb.push_back('{is_err: 1'b0, code: 2'b00, data: 8'h3C});
    a0       = n_accept;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    fork
      dev_xfer(11, 45, 1'b0, 0);
      begin
        ok = 0;
        for (int i = 0; i < 6000; i++) begin
          @(negedge clk);
          if (tx_done) begin ok = 1; break; end
        end
        tx_valid = 1'b0;
        chk("held_done_seen", ok, 1);
      end
    join
    wait_quiet(2000);
    chk("single_accept", n_accept - a0, 1);

    for (int r = 0; r < 6; r++) begin
      b    = 8'($urandom_range(0, 255));
      half = $urandom_range(30, 70);
      nack = ($urandom_range(0, 3) == 0);
      run_xfer(b, 11, half, nack, 0, nack, nack ? 2'b11 : 2'b00);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter that sends single command bytes to the keyboard on the shared PS2_CLK/PS2_DATA lines. Examples are 0xED LED-set, 0xFF reset and 0xF3 typematic. It is the send-direction counterpart of the keyboard decoder and sits beside it in top. Top converts the two `*_oe` outputs to open-drain: a line is driven 0 when its oe is 1, otherwise high-Z. While `busy` is high, top gates the decoder.

## Interface
- INHIBIT_CYCLES, 10000: clock-low hold before request-to-send (100 µs at 100 MHz).
- REQ_CYCLES, 16: cycles both lines are held low before clock release.
- START_TIMEOUT_CYCLES, 1500000: max wait for the first device falling edge (15 ms).
- XFER_TIMEOUT_CYCLES, 200000: max time from the first falling edge to the end of ACK (2 ms).
- FILTER_CYCLES, 8: stability required on synced ps2_clk before an edge is accepted.
- clk  in  1  system clock, 100 MHz. One clock; reset is asynchronous and active-low (rst_n).
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request; accepted when tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse on a successful ACKed transfer.
- tx_err  out  1  one-cycle pulse on failure.
- err_code  out  2  valid with tx_err and held until the next accept: 01 no-clock timeout, 10 transfer timeout, 11 NACK.
- ps2_clk_in  in  1  raw PS2_CLK pin.
- ps2_data_in  in  1  raw PS2_DATA pin.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_data_oe  out  1  1 = pull PS2_DATA low.

## Operation
- Both inputs pass through a 2-flop synchronizer.
- ps2_clk is accepted as a new level only after it has been stable for FILTER_CYCLES. A falling edge is a filtered 1→0 transition.
- On accept: latch tx_data into the shifter; parity = ~^tx_data (odd parity); err_code ← 00.
- States:
  - IDLE: both oe = 0, tx_ready = 1.
  - INHIBIT: clk_oe = 1, data_oe = 0, for INHIBIT_CYCLES cycles.
  - REQ: clk_oe = 1, data_oe = 1 (start bit), for REQ_CYCLES cycles.
  - WAIT_CLK: clk_oe = 0, data_oe = 1, waiting for the first falling edge.
    - Timeout (START_TIMEOUT_CYCLES) → ERR with code 01.
  - SEND: bit counter n counts falling edges 1..11, with XFER_TIMEOUT_CYCLES running from edge 1.
    - Edges 1–8: data_oe = ~data[n-1], LSB first.
    - Edge 9: data_oe = ~parity.
    - Edge 10: data_oe = 0 (stop bit, line released).
    - Edge 11: sample synced ps2_data; 0 → WAIT_IDLE, 1 → ERR with code 11.
    - Timeout → ERR with code 10.
  - WAIT_IDLE: both oe = 0 until synced clk and data are both 1 for FILTER_CYCLES; then tx_done pulse → IDLE.
    - The XFER timeout still applies and gives code 10.
  - ERR: both oe = 0, one-cycle tx_err pulse → IDLE.
- tx_valid while busy is ignored (no queue); the requester must hold it until tx_ready.
- Timeout counters are $clog2(START_TIMEOUT_CYCLES+1) bits wide, saturating, and cleared on every state entry.

## Timing
- Reset (rst_n = 0, asynchronous): state IDLE; ps2_clk_oe = ps2_data_oe = 0 immediately; tx_done = tx_err = 0; err_code = 00; busy = 0; tx_ready = 1 once rst_n is released.
- Reset mid-transfer releases both lines in the same instant, with no done or err pulse.
- Accept cycle T: busy = 1 and clk_oe = 1 at T+1.
- Start bit: data_oe rises at T+1+INHIBIT_CYCLES; clk_oe falls REQ_CYCLES later.
- Edge latency: pin falling edge → data_oe update = 2 (sync) + FILTER_CYCLES + 1 cycles. This must stay well under 30 µs (the minimum device low phase).
- tx_done and tx_err are mutually exclusive, and exactly one of them fires per accepted byte.
- tx_ready returns high the cycle after the done or err pulse.
- An edge and a timeout in the same cycle: the timeout wins.
- Glitches shorter than FILTER_CYCLES on ps2_clk never advance n.

## Test plan
- Device model clocks at 12.5 kHz and ACKs; send 0xED → the model receives bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulses once; err_code = 00; clk_oe was low ≥ 10000 cycles.
- Send 0x00 → the model sees parity 1; send 0xFF → parity 1; send 0x01 → parity 0. All complete with tx_done.
- Model never clocks → tx_err with err_code = 01 at 1500000 cycles after WAIT_CLK entry; both oe = 0.
- Model stops after 5 edges → tx_err with err_code = 10, 200000 cycles after edge 1.
- Model returns data = 1 at edge 11 → tx_err with err_code = 11, no tx_done.
- Assert rst_n = 0 after edge 4 → both oe = 0 asynchronously, busy = 0. tx_valid held during a transfer is not re-accepted until tx_ready = 1. A 5-cycle low glitch on ps2_clk does not advance the bit counter.
